// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared definitions for the codec audio datapath: default
//               sample width and the state encoding of the interpolating
//               upsampler on the DAC path.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Default sample width, signed two's complement
    localparam int AUDIO_DATA_WIDTH = 24;

    // Interpolator states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        FILL0 = 2'd0,   // waiting for the first sample of a segment pair
        FILL1 = 2'd1,   // waiting for the second sample of a segment pair
        RUN   = 2'd2,   // producing interpolated samples
        STALL = 2'd3    // boundary reached with no next sample; holding
    } interp_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/interpolation_filter_8.sv
`default_nettype none
// ============================================================================
// Module      : interpolation_filter_8
// Description : Linear-interpolation upsampler for the DAC path. Takes signed
//               low-rate samples over valid/ready and emits INTERP_FACTOR
//               linearly interpolated samples per input interval, one per
//               out_enable strobe from the DAC serializer.
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset
//               in_valid   - signal carries a new low-rate sample
//               in_ready   - block can accept a sample this cycle
//               signal     - signed input sample
//               out_enable - one-cycle request for the next output sample
//               result     - signed interpolated output (registered)
//               out_valid  - one-cycle pulse, result updated this cycle
//               underrun   - sticky, a segment boundary had no next sample
// Revision    : 1.0 - initial release
// ============================================================================
module interpolation_filter_8
    import audio_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = audio_pkg::AUDIO_DATA_WIDTH,
    parameter int INTERP_FACTOR    = 8,
    parameter int N                = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [AUDIO_DATA_WIDTH-1:0] signal,
    input  logic                        out_enable,
    output logic [AUDIO_DATA_WIDTH-1:0] result,
    output logic                        out_valid,
    output logic                        underrun
);

    localparam int           W      = AUDIO_DATA_WIDTH;
    localparam logic [N-1:0] K_LAST = N'(INTERP_FACTOR - 1);

    interp_state_t      r_state;
    interp_state_t      w_next_state;

    logic [W-1:0]       r_prev;
    logic [W-1:0]       r_curr;
    logic [W-1:0]       r_hold;
    logic               r_hold_full;
    logic [W:0]         r_step;
    logic [W+N:0]       r_acc;
    logic [N-1:0]       r_k;

    logic               w_accept;
    logic               w_boundary;
    logic               w_new_avail;
    logic [W-1:0]       w_new_sample;
    logic [W:0]         w_new_step;
    logic [W:0]         w_from_prev_step;
    logic [W+N:0]       w_curr_scaled;
    logic [W+N:0]       w_prev_scaled;
    logic [W+N:0]       w_step_ext;

    // ------------------------------------------------------------------------
    // Handshake and segment-boundary decode
    // ------------------------------------------------------------------------
    assign w_accept     = in_valid && in_ready;
    assign w_boundary   = (r_state == RUN) && out_enable && (r_k == K_LAST);

    // The skid entry has priority; when it is empty a sample arriving on the
    // boundary cycle bypasses it and feeds the new segment directly.
    assign w_new_avail  = r_hold_full || w_accept;
    assign w_new_sample = r_hold_full ? r_hold : signal;

    // Differences are formed at W+1 bits so a full-scale swing cannot wrap.
    assign w_new_step       = {w_new_sample[W-1], w_new_sample} - {r_curr[W-1], r_curr};
    assign w_from_prev_step = {signal[W-1], signal} - {r_prev[W-1], r_prev};

    // Accumulator holds sample * INTERP_FACTOR, so the interpolant is acc>>>N.
    assign w_curr_scaled = {r_curr[W-1], r_curr, {N{1'b0}}};
    assign w_prev_scaled = {r_prev[W-1], r_prev, {N{1'b0}}};
    assign w_step_ext    = {{N{r_step[W]}}, r_step};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL0;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and ready decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b1;
        case (r_state)
            FILL0: if (w_accept) w_next_state = FILL1;
            FILL1: if (w_accept) w_next_state = RUN;
            RUN: begin
                in_ready = !r_hold_full;
                if (w_boundary && !w_new_avail) w_next_state = STALL;
            end
            STALL: if (w_accept) w_next_state = RUN;
            default: w_next_state = FILL0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= '0;
            r_curr      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_step      <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            result      <= '0;
            out_valid   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            // Every state answers a strobe, so the pulse tracks the request.
            out_valid <= out_enable;

            case (r_state)
                FILL0: begin
                    if (out_enable) result <= '0;
                    if (w_accept)   r_prev <= signal;
                end

                FILL1: begin
                    if (out_enable) result <= '0;
                    if (w_accept) begin
                        r_curr <= signal;
                        r_acc  <= w_prev_scaled;
                        r_step <= w_from_prev_step;
                        r_k    <= '0;
                    end
                end

                RUN: begin
                    // A sample arriving mid-segment parks in the skid entry.
                    if (w_accept && !w_boundary) begin
                        r_hold      <= signal;
                        r_hold_full <= 1'b1;
                    end
                    if (out_enable) begin
                        result <= r_acc[N +: W];
                        if (r_k == K_LAST) begin
                            r_prev <= r_curr;
                            r_acc  <= w_curr_scaled;
                            r_k    <= '0;
                            if (w_new_avail) begin
                                r_curr      <= w_new_sample;
                                r_step      <= w_new_step;
                                r_hold_full <= 1'b0;
                            end else begin
                                r_step   <= '0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            r_acc <= r_acc + w_step_ext;
                            r_k   <= r_k + 1'b1;
                        end
                    end
                end

                STALL: begin
                    // The held value is emitted before any switch to the new
                    // segment, even when both happen on the same cycle.
                    if (out_enable) result <= r_prev;
                    if (w_accept) begin
                        r_curr <= signal;
                        r_step <= w_from_prev_step;
                        r_acc  <= w_prev_scaled;
                        r_k    <= '0;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule : interpolation_filter_8
`default_nettype wire

// File: tb/tb_interpolation_filter_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_interpolation_filter_8
// Description : Directed self-checking bench for interpolation_filter_8 with
//               hand-computed expected output sequences.
// Ports       : none (testbench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interpolation_filter_8;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] signal;
    logic         out_enable;
    logic [W-1:0] result;
    logic         out_valid;
    logic         underrun;

    int n_checks = 0;
    int n_fail   = 0;

    interpolation_filter_8 #(
        .AUDIO_DATA_WIDTH (W),
        .INTERP_FACTOR    (8),
        .N                (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .signal     (signal),
        .out_enable (out_enable),
        .result     (result),
        .out_valid  (out_valid),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_enable = 1'b0;
        signal     = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input int s);
        int guard;
        signal   = W'(s);
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic strobe(input string tag, input int exp);
        out_enable = 1'b1;
        tick();
        out_enable = 1'b0;
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk(tag, $signed(result), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: ramp 0 -> 800, next sample parked so no underrun ----
        do_reset();
        chk("rst_result",   $signed(result), 0);
        chk("rst_valid",    int'(out_valid), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_ready",    int'(in_ready), 1);
        push(0);
        push(800);
        push(1600);
        for (int k = 0; k < 8; k++) strobe("t1_ramp", k * 100);
        tick();
        chk("t1_valid_drop", int'(out_valid), 0);
        chk("t1_underrun",   int'(underrun), 0);

        // ---- 2: negative slope floors exactly, then upward segment ----
        do_reset();
        push(0);
        push(-8);
        push(8);
        for (int k = 0; k < 8; k++) strobe("t2_down", -k);
        for (int k = 0; k < 8; k++) strobe("t2_up", -8 + 2 * k);

        // ---- 3: skid full blocks the next sample until the boundary ----
        do_reset();
        push(0);
        push(800);
        push(1600);
        signal   = W'(2400);
        in_valid = 1'b1;
        chk("t3_ready_full", int'(in_ready), 0);
        for (int k = 0; k < 7; k++) strobe("t3_seg0", k * 100);
        chk("t3_ready_still", int'(in_ready), 0);
        strobe("t3_seg0_last", 700);
        chk("t3_ready_free", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("t3_ready_refull", int'(in_ready), 0);
        for (int k = 0; k < 8; k++) strobe("t3_seg1", 800 + k * 100);
        strobe("t3_seg2", 1600);

        // ---- 4: underrun, stall holds, resume on a new sample ----
        do_reset();
        push(0);
        push(800);
        for (int k = 0; k < 8; k++) strobe("t4_ramp", k * 100);
        chk("t4_underrun_set", int'(underrun), 1);
        for (int k = 0; k < 4; k++) strobe("t4_stall", 800);
        chk("t4_underrun_sticky", int'(underrun), 1);
        chk("t4_stall_ready", int'(in_ready), 1);
        push(0);
        for (int k = 0; k < 8; k++) strobe("t4_resume", 800 - k * 100);

        // ---- 5: sample accepted on the boundary strobe bypasses the skid ----
        do_reset();
        push(0);
        push(800);
        for (int k = 0; k < 7; k++) strobe("t5_ramp", k * 100);
        signal     = W'(1600);
        in_valid   = 1'b1;
        out_enable = 1'b1;
        tick();
        in_valid   = 1'b0;
        out_enable = 1'b0;
        chk("t5_last", $signed(result), 700);
        chk("t5_no_underrun", int'(underrun), 0);
        for (int k = 0; k < 8; k++) strobe("t5_next", 800 + k * 100);

        // ---- 6: full-scale swings, then reset mid-segment ----
        do_reset();
        push(-8388608);
        push(8388607);
        // -2^23 + floor(k*(2^24-1)/8) = -2^23 + k*2^21 - 1 for k>0
        for (int k = 0; k < 8; k++)
            strobe("t6_rise", (k == 0) ? -8388608 : (-8388608 + k * 2097152 - 1));
        push(-8388608);
        // 2^23-1 - k*(2^24-1)/8 floors to 2^23-1 - k*2^21 for k<8
        for (int k = 0; k < 4; k++) strobe("t6_fall", 8388607 - k * 2097152);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_result",   $signed(result), 0);
        chk("t6_rst_valid",    int'(out_valid), 0);
        chk("t6_rst_underrun", int'(underrun), 0);
        chk("t6_rst_ready",    int'(in_ready), 1);
        strobe("t6_fill_silence", 0);
        push(0);
        push(800);
        for (int k = 0; k < 3; k++) strobe("t6_restart", k * 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_interpolation_filter_8
`default_nettype wire
